// File: rtl/vc_channel_buffer.sv
// Router input-link buffer: NUM_VC virtual channels, each with a DEPTH-entry FIFO.
// A rotating phase picks the VC written (phase) and the VC read (phase+1).
// Optional saturating drop counter is built when VC_DROP_CNT_EN is defined.
module vc_channel_buffer #(
  parameter  int DATA_W = 64,
  parameter  int NUM_VC = 2,
  parameter  int DEPTH  = 4,
  localparam int VC_W   = $clog2(NUM_VC),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    si,
  input  logic [DATA_W-1:0]       packet_in,
  output logic                    ri,
  output logic                    so,
  input  logic                    ro,
  output logic [DATA_W-1:0]       packet_out,
  output logic [VC_W-1:0]         polarity,
  output logic [NUM_VC*CNT_W-1:0] occupancy,
  output logic                    err_vc,
  output logic [15:0]             drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [VC_W-1:0]   phase_q, phase_d;
  logic [VC_W-1:0]   wv, rv;
  logic [CNT_W-1:0]  cnt_q    [NUM_VC];
  logic [CNT_W-1:0]  cnt_d    [NUM_VC];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_VC];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_VC];
  logic [DATA_W-1:0] mem_q    [NUM_VC][DEPTH];
  logic              err_vc_q, err_vc_d;
  logic              vc_match, push, pop, drop;

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    phase_d  = phase_q + VC_W'(1);
    wv       = phase_q;
    rv       = phase_q + VC_W'(1);
    vc_match = (packet_in[DATA_W-1 -: VC_W] == wv);
    ri       = (cnt_q[wv] != CNT_W'(DEPTH));
    so       = (cnt_q[rv] != '0);
    packet_out = so ? mem_q[rv][rd_ptr_q[rv]] : '0;
    push     = si & ri & vc_match;
    drop     = si & ri & ~vc_match;
    pop      = so & ro;
    err_vc_d = drop;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // wv and rv always differ, so push and pop touch disjoint entries.
    if (push) begin
      cnt_d[wv]    = cnt_q[wv] + CNT_W'(1);
      wr_ptr_d[wv] = wr_ptr_q[wv] + PTR_W'(1);
    end
    if (pop) begin
      cnt_d[rv]    = cnt_q[rv] - CNT_W'(1);
      rd_ptr_d[rv] = rd_ptr_q[rv] + PTR_W'(1);
    end
  end

  always_comb begin
    occupancy = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      occupancy[v*CNT_W +: CNT_W] = cnt_q[v];
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q  <= '0;
      err_vc_q <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
        cnt_q[v]    <= '0;
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
      end
    end else begin
      phase_q  <= phase_d;
      err_vc_q <= err_vc_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: packet storage is not reset; counts gate every read, so stale data never escapes.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wv][wr_ptr_q[wv]] <= packet_in;
    end
  end

  assign polarity = phase_q;
  assign err_vc   = err_vc_q;

`ifdef VC_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= 16'h0000;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: doc/vc_channel_buffer.md
Name: vc_channel_buffer

Overview:
- Parametrised successor of the fixed 64-bit, two-channel router link buffer.
- One router input link is split into NUM_VC virtual channels, each with its own DEPTH-entry FIFO.
- A free-running phase counter generalises the even/odd polarity scheme to NUM_VC phases. In each phase, the link accepts one VC and forwards the next VC.
- Instantiated once per router direction (E/W/S/N/PE) in the next-generation router.

Parameters:
DATA_W, 64, packet width in bits
NUM_VC, 2, number of virtual channels; power of 2, at least 2
DEPTH, 4, entries per VC FIFO; power of 2, at least 2
VC_W, $clog2(NUM_VC), width of the VC field and the phase (derived, not overridden)
CNT_W, $clog2(DEPTH+1), width of one occupancy field (derived)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
si  in  1  upstream send: packet_in valid
packet_in  in  DATA_W  incoming packet; VC field is packet_in[DATA_W-1 -: VC_W]
ri  out  1  ready to upstream
so  out  1  downstream send: packet_out valid
ro  in  1  downstream ready
packet_out  out  DATA_W  outgoing packet
polarity  out  VC_W  current phase
occupancy  out  NUM_VC*CNT_W  per-VC entry count; VC v occupies bits [v*CNT_W +: CNT_W]
err_vc  out  1  one-cycle pulse: packet dropped on VC mismatch
drop_cnt  out  16  saturating count of dropped packets (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous): phase=0, all FIFO pointers and counts=0, err_vc=0, drop_cnt=0. Outputs then read ri=1, so=0, packet_out=0, occupancy=0. Reset mid-operation discards all buffered packets and ignores any handshake in that cycle.
- Phase: increments by 1 every clock after reset and wraps from NUM_VC-1 to 0. polarity = phase. No enable.
- Write VC: wv = phase. Read VC: rv = (phase+1) mod NUM_VC.
  - wv is never equal to rv, so push and pop never target the same FIFO in one cycle.
- Input side:
  - ri = (count[wv] != DEPTH). ri is combinational from registered state and does not depend on si.
  - Accept when si & ri & (packet_in VC field == wv): store packet_in at the tail of FIFO wv and increment count[wv].
  - Drop when si & ri & (VC field != wv): nothing is stored, and err_vc=1 in the next cycle (registered).
  - si & !ri: no effect. Upstream must hold the packet.
- Output side:
  - so = (count[rv] != 0).
  - packet_out = head of FIFO rv when so=1, else all-zero. Combinational read of registered storage.
  - Pop when so & ro: advance the FIFO rv read pointer and decrement count[rv].
  - so & !ro: nothing is popped. The packet is retried when rv next equals that VC, NUM_VC cycles later.
- Pointers: per-VC read and write pointers of $clog2(DEPTH) bits, wrapping naturally. Full/empty are decided only from count.
- Latency: a packet accepted in cycle t on VC v appears on packet_out at cycle t+NUM_VC-1 at the earliest. For NUM_VC=2 that is t+1.
- Ordering: FIFO order within a VC. No ordering guarantee across VCs.
- Full boundary: count[wv]=DEPTH gives ri=0. Because no pop can occur on wv in the same cycle, there is no write-through when full.
- Empty boundary: count[rv]=0 gives so=0 and packet_out=0. ro is ignored.

Optional Feature:
- Macro: VC_DROP_CNT_EN.
- Defined: drop_cnt increments by 1 on every drop event (the same cycle err_vc is registered) and saturates at 16'hFFFF. It is cleared only by reset.
- Undefined: drop_cnt is tied to 16'h0000 and no counter logic is generated. err_vc behaviour is identical in both builds.

Test Plan:
- Defaults, reset released, ro=1, no si -> polarity toggles 0,1,0,1; ri=1, so=0, packet_out=0, occupancy=0.
- Phase 0: si=1, packet_in=64'h0000_0000_0000_00AA (VC0) -> occupancy VC0=1 next cycle; in that phase-1 cycle so=1, packet_out=...AA; after the pop, occupancy=0.
- ro=0, with 4 VC0 packets 0x1..0x4 sent on successive phase-0 cycles -> VC0 count=4, ri=0 in phase 0; 5th packet 0x5 is not accepted; set ro=1 -> outputs 0x1,0x2,0x3,0x4 on phase-1 cycles, in order.
- Phase 0: si=1, packet_in=64'h8000_0000_0000_0055 (VC1) -> not stored; err_vc=1 for one cycle; drop_cnt=1 with VC_DROP_CNT_EN defined, 0 without.
- NUM_VC=4, DEPTH=2: inject packets with VC 2'b10 and 2'b11 in phases 2 and 3 -> VC2 packet output in phase 1, VC3 packet output in phase 2; polarity cycles 0-3.
- Load 3 packets, then assert reset=0 mid-cycle, asynchronously -> immediately so=0, occupancy=0, polarity=0; after release, no stale packets appear.
